// File: rtl/switch_box_cfg_chain.sv
// Purpose : W-track-per-side routing switch box; pass switches gated by an on-block
//           active config register loaded from a daisy-chained serial shadow register.
// Latency : shift updates shadow/cfg_out at the edge; accepted commit changes switches 1 cycle later.
// Backpressure: none; cfg_ready reports a full chain, bad commits raise sticky cfg_err.
//
// Ports:
//   clk, rst_n        configuration clock, asynchronous active-low reset
//   cfg_shift_en      shift one bit of cfg_in into the shadow chain this cycle
//   cfg_in / cfg_out  serial chain in / out (cfg_out is the shadow MSB)
//   cfg_commit        copy shadow -> active (only when chain is exactly loaded, no shift)
//   cfg_ready         chain loaded with a full word since the last commit
//   cfg_err           sticky: last commit attempt was rejected
//   north/east/south/west  W routing tracks per side
//
// Optional build macro: SB_CFG_PARITY_EN adds an even-parity bit (shifted last) to the chain;
// a commit whose NB+1 shadow bits do not XOR to zero is rejected.
module switch_box_cfg_chain #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cfg_shift_en,
    input  logic         cfg_in,
    output logic         cfg_out,
    input  logic         cfg_commit,
    output logic         cfg_ready,
    output logic         cfg_err,
    inout  wire  [W-1:0] north,
    inout  wire  [W-1:0] east,
    inout  wire  [W-1:0] south,
    inout  wire  [W-1:0] west
);

    localparam int NB = 6 * W;
`ifdef SB_CFG_PARITY_EN
    localparam int CL = NB + 1;
`else
    localparam int CL = NB;
`endif
    localparam int            CW   = $clog2(CL + 1);
    localparam logic [CW-1:0] FULL = CW'(CL);

    logic [CL-1:0] shadow;
    logic [NB-1:0] active;
    logic [NB-1:0] shadow_data;
    logic [CW-1:0] count;
    logic          parity_ok;
    logic          commit_try;
    logic          commit_ok;

`ifdef SB_CFG_PARITY_EN
    // Parity bit sits at the LSB end because it is the last bit shifted in.
    assign shadow_data = shadow[CL-1:1];
    assign parity_ok   = ~(^shadow);
`else
    assign shadow_data = shadow;
    assign parity_ok   = 1'b1;
`endif

    assign cfg_ready  = (count == FULL);
    assign cfg_out    = shadow[CL-1];
    // A commit is only considered on a quiet, exactly-loaded chain; anything else is rejected.
    assign commit_try = cfg_commit & ~cfg_shift_en & cfg_ready;
    assign commit_ok  = commit_try & parity_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow  <= '0;
            active  <= '0;
            count   <= '0;
            cfg_err <= 1'b0;
        end else begin
            if (cfg_shift_en) begin
                shadow <= {shadow[CL-2:0], cfg_in};
                if (count != FULL) begin
                    count <= count + 1'b1;
                end
            end
            // Both an accepted and a parity-failed commit consume the loaded word.
            if (commit_try) begin
                count <= '0;
            end
            if (commit_ok) begin
                active  <= shadow_data;
                cfg_err <= 1'b0;
            end else if (cfg_commit) begin
                cfg_err <= 1'b1;
            end
        end
    end

    // Bidirectional pass switches: each closed switch drives each side from the other.
    // Track i turns onto track j = (i+1) mod W, which collapses to j = i when W = 1.
    for (genvar i = 0; i < W; i++) begin : g_trk
        localparam int J = (i + 1) % W;
        localparam int B = 6 * i;

        // m=0: N[i]-E[i]
        assign east[i]  = active[B+0] ? north[i] : 1'bz;
        assign north[i] = active[B+0] ? east[i]  : 1'bz;
        // m=1: E[i]-S[j]
        assign south[J] = active[B+1] ? east[i]  : 1'bz;
        assign east[i]  = active[B+1] ? south[J] : 1'bz;
        // m=2: S[i]-W[i]
        assign west[i]  = active[B+2] ? south[i] : 1'bz;
        assign south[i] = active[B+2] ? west[i]  : 1'bz;
        // m=3: W[i]-N[j]
        assign north[J] = active[B+3] ? west[i]  : 1'bz;
        assign west[i]  = active[B+3] ? north[J] : 1'bz;
        // m=4: N[i]-S[i]
        assign south[i] = active[B+4] ? north[i] : 1'bz;
        assign north[i] = active[B+4] ? south[i] : 1'bz;
        // m=5: E[i]-W[i]
        assign west[i]  = active[B+5] ? east[i]  : 1'bz;
        assign east[i]  = active[B+5] ? west[i]  : 1'bz;
    end

endmodule

// File: tb/tb_switch_box_cfg_chain.sv
// Purpose : directed bench for switch_box_cfg_chain (W=2), two boxes daisy-chained u0 -> u1.
// Latency : inputs driven 1 time unit after posedge, outputs sampled at the same offset.
// Backpressure: n/a; all sequences are fixed-length, so the run always terminates.
module tb_switch_box_cfg_chain;

    localparam int W  = 2;
    localparam int NB = 6 * W;
`ifdef SB_CFG_PARITY_EN
    localparam int CL = NB + 1;
`else
    localparam int CL = NB;
`endif

    logic clk = 1'b0;
    logic rst_n, sh, din, commit0, commit1;
    logic cfg_out0, cfg_out1, ready0, ready1, err0, err1;

    wire  [W-1:0] n0, e0, s0, w0, n1, e1, s1, w1;
    logic [W-1:0] n0_en, n0_val, n1_en, n1_val, w1_en, w1_val;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar b = 0; b < W; b++) begin : g_drv
        assign n0[b] = n0_en[b] ? n0_val[b] : 1'bz;
        assign n1[b] = n1_en[b] ? n1_val[b] : 1'bz;
        assign w1[b] = w1_en[b] ? w1_val[b] : 1'bz;
    end

    switch_box_cfg_chain #(.W(W)) u0 (
        .clk(clk), .rst_n(rst_n), .cfg_shift_en(sh), .cfg_in(din), .cfg_out(cfg_out0),
        .cfg_commit(commit0), .cfg_ready(ready0), .cfg_err(err0),
        .north(n0), .east(e0), .south(s0), .west(w0)
    );

    switch_box_cfg_chain #(.W(W)) u1 (
        .clk(clk), .rst_n(rst_n), .cfg_shift_en(sh), .cfg_in(cfg_out0), .cfg_out(cfg_out1),
        .cfg_commit(commit1), .cfg_ready(ready1), .cfg_err(err1),
        .north(n1), .east(e1), .south(s1), .west(w1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    function automatic logic is1(input logic v);
        return (v === 1'b1);
    endfunction

    // Serial image of a config word: data MSB first, even-parity bit last when enabled.
    function automatic logic [63:0] enc(input logic [NB-1:0] d);
        logic [63:0] r;
        r = '0;
`ifdef SB_CFG_PARITY_EN
        r[CL-1:0] = {d, ^d};
`else
        r[CL-1:0] = d;
`endif
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Shifts v[n-1] first, down to v[0].
    task automatic shift_bits(input logic [63:0] v, input int n);
        for (int k = n - 1; k >= 0; k--) begin
            din = v[k];
            sh  = 1'b1;
            tick();
        end
        sh  = 1'b0;
        din = 1'b0;
    endtask

    task automatic do_commit(input logic c0, input logic c1);
        commit0 = c0;
        commit1 = c1;
        tick();
        commit0 = 1'b0;
        commit1 = 1'b0;
    endtask

    initial begin
        logic [63:0] v;

        // Reset state; north[0] driven while every switch is open.
        rst_n = 1'b0; sh = 1'b0; din = 1'b0; commit0 = 1'b0; commit1 = 1'b0;
        n0_en = 2'b01; n0_val = 2'b01;
        n1_en = 2'b00; n1_val = 2'b00;
        w1_en = 2'b00; w1_val = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", ready0, 1'b0);
        check("rst_err", err0, 1'b0);
        check("rst_out", cfg_out0, 1'b0);
        check("rst_e0_open", is1(e0[0]), 1'b0);
        check("rst_s0_open", is1(s0[0]), 1'b0);
        check("rst_w0_open", is1(w0[0]), 1'b0);
        n0_val[0] = 1'b0;
        rst_n = 1'b1;

        // Load 12'h001 -> N[0]-E[0] only.
        shift_bits(enc(12'h001), CL);
        check("load1_ready", ready0, 1'b1);
        do_commit(1'b1, 1'b0);
        check("commit1_ready_drop", ready0, 1'b0);
        check("commit1_err", err0, 1'b0);
        check("ne_pass0", (e0[0] === 1'b0), 1'b1);
        n0_val[0] = 1'b1;
        #1;
        check("ne_pass1", is1(e0[0]), 1'b1);
        check("ne_e1_open", is1(e0[1]), 1'b0);
        check("ne_s0_open", is1(s0[0]), 1'b0);
        check("ne_w0_open", is1(w0[0]), 1'b0);

        // Partial load, early commit rejected; then finish load with 12'h010 (N[0]-S[0]).
        v = enc(12'h010);
        shift_bits(v >> (CL - 5), 5);
        do_commit(1'b1, 1'b0);
        check("early_err", err0, 1'b1);
        check("early_ready", ready0, 1'b0);
        check("early_active_kept", is1(e0[0]), 1'b1);
        shift_bits(v, CL - 5);
        check("load2_ready", ready0, 1'b1);
        do_commit(1'b1, 1'b0);
        check("commit2_err_clr", err0, 1'b0);
        check("ns_pass", is1(s0[0]), 1'b1);
        check("ns_e0_open", is1(e0[0]), 1'b0);

        // Commit together with a shift: rejected, but the shift still counts.
        sh = 1'b1; din = 1'b0; commit0 = 1'b1;
        tick();
        sh = 1'b0; commit0 = 1'b0;
        check("shcommit_err", err0, 1'b1);
        check("shcommit_active_kept", is1(s0[0]), 1'b1);
        shift_bits(64'h0, CL - 2);
        check("shcommit_cnt_not_full", ready0, 1'b0);
        shift_bits(64'h0, 1);
        check("shcommit_cnt_full", ready0, 1'b1);
        shift_bits(64'h0, 1);
        check("extra_shift_ready", ready0, 1'b1);

        // Two chained boxes: u1 gets the first CL bits, u0 the last CL bits.
        n0_en = 2'b11; n0_val = 2'b11;
        n1_en = 2'b01; n1_val = 2'b01;
        w1_en = 2'b10; w1_val = 2'b10;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        v = (enc(12'h810) << CL) | enc(12'h040);
        shift_bits(v >> (CL + 1), CL - 1);
        check("first_bit_not_yet_out", cfg_out0, 1'b0);
        shift_bits(v >> CL, 1);
        check("first_bit_out", cfg_out0, 1'b1);
        shift_bits(v, CL);
        check("chain_ready0", ready0, 1'b1);
        check("chain_ready1", ready1, 1'b1);
        do_commit(1'b1, 1'b1);
        check("chain_u0_ne1", is1(e0[1]), 1'b1);
        check("chain_u0_ne0_open", is1(e0[0]), 1'b0);
        check("chain_u1_ns0", is1(s1[0]), 1'b1);
        check("chain_u1_we1", is1(e1[1]), 1'b1);
        check("chain_err1", err1, 1'b0);

        // Asynchronous reset in the middle of a load.
        shift_bits(64'h0, 6);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_ready", ready0, 1'b0);
        check("midrst_u0_open", is1(e0[1]), 1'b0);
        check("midrst_u1_ns_open", is1(s1[0]), 1'b0);
        check("midrst_u1_we_open", is1(e1[1]), 1'b0);
        rst_n = 1'b1;
        shift_bits(64'h0, CL - 1);
        check("midrst_cnt_cleared", ready0, 1'b0);
        shift_bits(64'h0, 1);
        check("midrst_cnt_full", ready0, 1'b1);

`ifdef SB_CFG_PARITY_EN
        // 12'h001 with parity bit 0 has odd parity and must be rejected.
        shift_bits(64'h2, CL);
        do_commit(1'b1, 1'b0);
        check("par_bad_err", err0, 1'b1);
        check("par_bad_cnt_clr", ready0, 1'b0);
        check("par_bad_active_kept", is1(e0[0]), 1'b0);
        shift_bits(enc(12'h001), CL);
        do_commit(1'b1, 1'b0);
        check("par_good_err", err0, 1'b0);
        check("par_good_ne", is1(e0[0]), 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
